cpu_top_mem_bridge: RTL and testbench

//  Memory-side endpoint of the 32-bit serial controller<->memory link in the CPU top level.

---
 rtl/cpu_top_mem_bridge.sv | 175 +++++++++++++++++
 tb/tb_cpu_top_mem_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_top_mem_bridge.sv
// Memory-side endpoint of the controller<->memory serial link: turns 32-byte line
// read/write requests into 4-beat banked-memory bursts and returns lines/completions.
module cpu_top_mem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_data_bus_c_to_m,
    input  logic        address_on_c_to_m,
    input  logic        data_on_c_to_m,
    input  logic        read_en_c_to_m,
    input  logic        write_en_c_to_m,
    input  logic        resp_c_to_m,
    output logic [31:0] address_data_bus_m_to_c,
    output logic        address_on_m_to_c,
    output logic        data_on_m_to_c,
    output logic        read_en_m_to_c,
    output logic        write_en_m_to_c,
    output logic        resp_m_to_c,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_raddr,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int unsigned LINE_WORDS  = 8;
    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned OFFSET_W    = 5;
    localparam int unsigned WORD_IDX_W  = $clog2(LINE_WORDS);
    localparam int unsigned BEAT_IDX_W  = $clog2(BURST_BEATS);

    typedef enum logic [3:0] {
        IDLE, W_DATA, W_ISSUE, W_RESP, R_ISSUE, R_WAIT, R_ECHO, R_DATA, R_ACK
    } state_t;

    state_t                  r_state;
    logic [WORD_W-1:0]       r_line_addr;
    logic [WORD_W-1:0]       r_words [LINE_WORDS];
    logic [WORD_IDX_W-1:0]   r_word_idx;
    logic [BEAT_IDX_W-1:0]   r_beat_idx;
    logic                    r_burst_on;

    // Byte offset and returned beat address carry no information for a line transfer.
    logic w_unused_bits;
    assign w_unused_bits = ^{bmem_raddr, address_data_bus_c_to_m[OFFSET_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                 <= IDLE;
            r_line_addr             <= '0;
            r_word_idx              <= '0;
            r_beat_idx              <= '0;
            r_burst_on              <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= '0;
            end
            address_data_bus_m_to_c <= '0;
            address_on_m_to_c       <= 1'b0;
            data_on_m_to_c          <= 1'b0;
            read_en_m_to_c          <= 1'b0;
            write_en_m_to_c         <= 1'b0;
            resp_m_to_c             <= 1'b0;
            bmem_addr               <= '0;
            bmem_read               <= 1'b0;
            bmem_write              <= 1'b0;
            bmem_wdata              <= '0;
        end else begin
            // Every output is a pulse or a qualified bus; idle value is zero.
            address_data_bus_m_to_c <= '0;
            address_on_m_to_c       <= 1'b0;
            data_on_m_to_c          <= 1'b0;
            read_en_m_to_c          <= 1'b0;
            write_en_m_to_c         <= 1'b0;
            resp_m_to_c             <= 1'b0;
            bmem_addr               <= '0;
            bmem_read               <= 1'b0;
            bmem_write              <= 1'b0;
            bmem_wdata              <= '0;

            case (r_state)
                IDLE: begin
                    if (address_on_c_to_m && (read_en_c_to_m ^ write_en_c_to_m)) begin
                        r_line_addr <= {address_data_bus_c_to_m[WORD_W-1:OFFSET_W], OFFSET_W'(0)};
                        r_word_idx  <= '0;
                        r_beat_idx  <= '0;
                        r_burst_on  <= 1'b0;
                        r_state     <= write_en_c_to_m ? W_DATA : R_ISSUE;
                    end
                end

                W_DATA: begin
                    if (data_on_c_to_m) begin
                        r_words[r_word_idx] <= address_data_bus_c_to_m;
                        r_word_idx          <= r_word_idx + WORD_IDX_W'(1);
                        if (r_word_idx == WORD_IDX_W'(LINE_WORDS - 1)) begin
                            r_state <= W_ISSUE;
                        end
                    end
                end

                // Ready only gates the first beat; the rest follow back-to-back.
                W_ISSUE: begin
                    if (r_burst_on || bmem_ready) begin
                        r_burst_on <= 1'b1;
                        bmem_write <= 1'b1;
                        bmem_addr  <= r_line_addr;
                        bmem_wdata <= BEAT_W'({r_words[{r_beat_idx, 1'b1}], r_words[{r_beat_idx, 1'b0}]});
                        r_beat_idx <= r_beat_idx + BEAT_IDX_W'(1);
                        if (r_beat_idx == BEAT_IDX_W'(BURST_BEATS - 1)) begin
                            r_state <= W_RESP;
                        end
                    end
                end

                W_RESP: begin
                    resp_m_to_c             <= 1'b1;
                    address_on_m_to_c       <= 1'b1;
                    write_en_m_to_c         <= 1'b1;
                    address_data_bus_m_to_c <= r_line_addr;
                    r_state                 <= IDLE;
                end

                R_ISSUE: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b1;
                        bmem_addr <= r_line_addr;
                        r_state   <= R_WAIT;
                    end
                end

                R_WAIT: begin
                    if (bmem_rvalid) begin
                        r_words[{r_beat_idx, 1'b0}] <= bmem_rdata[WORD_W-1:0];
                        r_words[{r_beat_idx, 1'b1}] <= bmem_rdata[BEAT_W-1:WORD_W];
                        r_beat_idx                  <= r_beat_idx + BEAT_IDX_W'(1);
                        if (r_beat_idx == BEAT_IDX_W'(BURST_BEATS - 1)) begin
                            r_state <= R_ECHO;
                        end
                    end
                end

                R_ECHO: begin
                    address_on_m_to_c       <= 1'b1;
                    read_en_m_to_c          <= 1'b1;
                    address_data_bus_m_to_c <= r_line_addr;
                    r_word_idx              <= '0;
                    r_state                 <= R_DATA;
                end

                R_DATA: begin
                    data_on_m_to_c          <= 1'b1;
                    address_data_bus_m_to_c <= r_words[r_word_idx];
                    r_word_idx              <= r_word_idx + WORD_IDX_W'(1);
                    if (r_word_idx == WORD_IDX_W'(LINE_WORDS - 1)) begin
                        resp_m_to_c <= 1'b1;
                        r_state     <= R_ACK;
                    end
                end

                R_ACK: begin
                    if (resp_c_to_m) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_top_mem_bridge.sv
// Randomized directed-sequence bench for cpu_top_mem_bridge with a line-level
// reference model of the link and bmem transfers.
module tb_cpu_top_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address_data_bus_c_to_m;
    logic        address_on_c_to_m;
    logic        data_on_c_to_m;
    logic        read_en_c_to_m;
    logic        write_en_c_to_m;
    logic        resp_c_to_m;
    logic [31:0] address_data_bus_m_to_c;
    logic        address_on_m_to_c;
    logic        data_on_m_to_c;
    logic        read_en_m_to_c;
    logic        write_en_m_to_c;
    logic        resp_m_to_c;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] wd [8];
    logic [63:0] rb [4];

    cpu_top_mem_bridge dut (
        .clk                     (clk),
        .rst                     (rst),
        .address_data_bus_c_to_m (address_data_bus_c_to_m),
        .address_on_c_to_m       (address_on_c_to_m),
        .data_on_c_to_m          (data_on_c_to_m),
        .read_en_c_to_m          (read_en_c_to_m),
        .write_en_c_to_m         (write_en_c_to_m),
        .resp_c_to_m             (resp_c_to_m),
        .address_data_bus_m_to_c (address_data_bus_m_to_c),
        .address_on_m_to_c       (address_on_m_to_c),
        .data_on_m_to_c          (data_on_m_to_c),
        .read_en_m_to_c          (read_en_m_to_c),
        .write_en_m_to_c         (write_en_m_to_c),
        .resp_m_to_c             (resp_m_to_c),
        .bmem_addr               (bmem_addr),
        .bmem_read               (bmem_read),
        .bmem_write              (bmem_write),
        .bmem_wdata              (bmem_wdata),
        .bmem_ready              (bmem_ready),
        .bmem_raddr              (bmem_raddr),
        .bmem_rdata              (bmem_rdata),
        .bmem_rvalid             (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Link-level invariants that hold in every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rw_excl", 64'(bmem_read & bmem_write), 64'd0);
            if (!address_on_m_to_c && !data_on_m_to_c)
                chk("bus_idle", 64'(address_data_bus_m_to_c), 64'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic link_idle();
        address_on_c_to_m       = 1'b0;
        data_on_c_to_m          = 1'b0;
        read_en_c_to_m          = 1'b0;
        write_en_c_to_m         = 1'b0;
        resp_c_to_m             = 1'b0;
        address_data_bus_c_to_m = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_bus"}, 64'(address_data_bus_m_to_c), 64'd0);
        chk({tag, "_flags"}, 64'({address_on_m_to_c, data_on_m_to_c, read_en_m_to_c,
                                  write_en_m_to_c, resp_m_to_c}), 64'd0);
        chk({tag, "_baddr"}, 64'(bmem_addr), 64'd0);
        chk({tag, "_bctl"}, 64'({bmem_read, bmem_write}), 64'd0);
        chk({tag, "_wdata"}, bmem_wdata, 64'd0);
    endtask

    // Write request followed by the 8 data words with random gaps and stray requests.
    task automatic send_write(input logic [31:0] addr);
        @(negedge clk);
        link_idle();
        address_on_c_to_m       = 1'b1;
        write_en_c_to_m         = 1'b1;
        address_data_bus_c_to_m = addr;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                link_idle();
                if ($urandom_range(0, 1) == 1) begin
                    address_on_c_to_m = 1'b1;
                    read_en_c_to_m    = 1'b1;
                end
            end
            @(negedge clk);
            link_idle();
            data_on_c_to_m          = 1'b1;
            address_data_bus_c_to_m = wd[i];
        end
        @(negedge clk);
        link_idle();
    endtask

    // Observes the write burst and completion; ready is held low for bp cycles.
    task automatic finish_write(input logic [31:0] addr, input int bp);
        logic [31:0] line;
        int beats;
        int first;
        int resp_t;
        line   = {addr[31:5], 5'd0};
        beats  = 0;
        first  = -1;
        resp_t = -1;
        for (int t = 0; t < 80 && resp_t < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (bmem_write) begin
                chk("wr_addr", 64'(bmem_addr), 64'(line));
                if (beats < 4) chk("wr_data", bmem_wdata, {wd[2*beats+1], wd[2*beats]});
                if (beats == 0) first = t;
                else chk("wr_contig", 64'(t), 64'(first + beats));
                beats++;
            end
            if (resp_m_to_c) begin
                resp_t = t;
                chk("wr_echo_bus", 64'(address_data_bus_m_to_c), 64'(line));
                chk("wr_echo_flags", 64'({address_on_m_to_c, write_en_m_to_c, read_en_m_to_c,
                                          data_on_m_to_c}), 64'(4'b1100));
            end
            bmem_ready = (t >= bp);
        end
        bmem_ready = 1'b1;
        chk("wr_beats", 64'(beats), 64'd4);
        chk("wr_after_ready", 64'(first > bp), 64'd1);
        chk("wr_resp_seen", 64'(resp_t >= 0), 64'd1);
        chk("wr_latency", 64'(resp_t >= 5 && resp_t >= first + 4), 64'd1);
        @(negedge clk);
        chk("wr_resp_pulse", 64'(resp_m_to_c), 64'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int bp);
        bmem_ready = (bp == 0);
        send_write(addr);
        finish_write(addr, bp);
    endtask

    // Full read: bmem returns rb[], expected line words come from the half-word split.
    task automatic do_read(input logic [31:0] addr, input bit early, input bit probe);
        logic [31:0] line;
        logic [31:0] ew [8];
        int found;
        int echo_t;
        int nw;
        bit bad;
        line   = {addr[31:5], 5'd0};
        found  = -1;
        echo_t = -1;
        nw     = 0;
        for (int k = 0; k < 4; k++) begin
            ew[2*k]   = rb[k][31:0];
            ew[2*k+1] = rb[k][63:32];
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        link_idle();
        address_on_c_to_m       = 1'b1;
        read_en_c_to_m          = 1'b1;
        address_data_bus_c_to_m = addr;
        @(negedge clk);
        link_idle();
        for (int t = 0; t < 30 && found < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (bmem_read) begin
                found = t;
                chk("rd_addr", 64'(bmem_addr), 64'(line));
            end
        end
        chk("rd_issue", 64'(found >= 0), 64'd1);
        @(negedge clk);
        chk("rd_pulse", 64'(bmem_read), 64'd0);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = {$urandom, $urandom};
                @(negedge clk);
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = rb[k];
            bmem_raddr  = $urandom;
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
        for (int t = 0; t < 40 && nw < 8; t++) begin
            if (t > 0) @(negedge clk);
            if (address_on_m_to_c) begin
                echo_t = t;
                chk("rd_echo_bus", 64'(address_data_bus_m_to_c), 64'(line));
                chk("rd_echo_flags", 64'({read_en_m_to_c, write_en_m_to_c, data_on_m_to_c,
                                          resp_m_to_c}), 64'(4'b1000));
            end
            if (data_on_m_to_c) begin
                chk("rd_word", 64'(address_data_bus_m_to_c), 64'(ew[nw]));
                chk("rd_seq", 64'(t), 64'(echo_t + 1 + nw));
                chk("rd_resp", 64'(resp_m_to_c), 64'(nw == 7));
                nw++;
            end
            resp_c_to_m = early && (t < 3);
        end
        resp_c_to_m = 1'b0;
        chk("rd_words", 64'(nw), 64'd8);
        if (probe) begin
            address_on_c_to_m       = 1'b1;
            read_en_c_to_m          = 1'b1;
            address_data_bus_c_to_m = $urandom;
            bad = 1'b0;
            repeat (8) begin
                @(negedge clk);
                link_idle();
                if (bmem_read || bmem_write || address_on_m_to_c || data_on_m_to_c || resp_m_to_c)
                    bad = 1'b1;
            end
            chk("rd_ack_gate", 64'(bad), 64'd0);
        end
        resp_c_to_m = 1'b1;
        @(negedge clk);
        link_idle();
    endtask

    initial begin
        bit bad;
        int found;
        link_idle();
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Directed write of words 0x11..0x88.
        for (int i = 0; i < 8; i++) wd[i] = 32'((i + 1) * 32'h11);
        do_write(32'h1000_0020, 0);

        // Directed read with unaligned address.
        for (int k = 0; k < 4; k++) rb[k] = {32'(2*k + 11), 32'(2*k + 10)};
        do_read(32'h1000_0047, 1'b0, 1'b0);

        // Backpressure of 10 cycles before the write burst.
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        do_write(32'h2000_1234, 10);

        // Illegal and unqualified requests plus stray data in IDLE.
        @(negedge clk);
        link_idle();
        address_on_c_to_m = 1'b1;
        read_en_c_to_m    = 1'b1;
        write_en_c_to_m   = 1'b1;
        @(negedge clk);
        link_idle();
        address_on_c_to_m = 1'b1;
        @(negedge clk);
        link_idle();
        data_on_c_to_m = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            link_idle();
            if (bmem_read || bmem_write || address_on_m_to_c || data_on_m_to_c || resp_m_to_c)
                bad = 1'b1;
        end
        chk("illegal_idle", 64'(bad), 64'd0);
        for (int k = 0; k < 4; k++) rb[k] = {$urandom, $urandom};
        do_read(32'h3000_00C0, 1'b0, 1'b0);

        // Early ack and a read sent before the ack are both ignored.
        for (int k = 0; k < 4; k++) rb[k] = {$urandom, $urandom};
        do_read(32'h4000_0100, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) rb[k] = {$urandom, $urandom};
        do_read(32'h4000_0140, 1'b0, 1'b0);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        bmem_ready = 1'b1;
        send_write(32'h5000_0060);
        found = -1;
        for (int t = 0; t < 20 && found < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (bmem_write) found = t;
        end
        chk("rst_burst_started", 64'(found >= 0), 64'd1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bmem_read || bmem_write || resp_m_to_c) bad = 1'b1;
        end
        chk("rst_aborted", 64'(bad), 64'd0);
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        do_write(32'h5000_0080, 0);

        // Randomized mix against the line-level model.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) wd[i] = $urandom;
                do_write($urandom, int'($urandom_range(0, 4)));
            end else begin
                for (int k = 0; k < 4; k++) rb[k] = {$urandom, $urandom};
                do_read($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
